qed_issue_sequencer: RTL and testbench

//  Sits between the fetch stage and decode in the SQED harness. Each constrained

---
 rtl/qed_issue_sequencer.sv | 137 +++++++++++++
 tb/tb_qed_issue_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/qed_issue_sequencer.sv
// SQED issue sequencer: issues constrained originals while queueing them, then
// replays the queue in order as duplicates (r16-r31, duplicate memory half).
module qed_issue_sequencer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec_dup,
  input  logic [31:0]      ifu_inst,
  input  logic             ifu_valid,
  output logic             ifu_ready,
  input  logic             stall,
  output logic [31:0]      inst_out,
  output logic             inst_valid,
  output logic             dup_mode,
  output logic [CNT_W-1:0] num_orig,
  output logic [CNT_W-1:0] num_dup,
  output logic             qed_ready,
  output logic [1:0]       o_dbg_state
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [31:0]      NOP      = 32'h1500_0000;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_ORIG = 2'd0,
    S_DUP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: an original is consumed on a cycle where ifu_valid && ifu_ready;
  // ifu_ready never depends on ifu_valid. inst_out is meaningful when inst_valid.
  state_t           r_state, w_state_d;
  logic [31:0]      r_fifo [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_fifo_cnt;
  logic [31:0]      r_inst_out, w_out_d;
  logic             r_inst_valid, w_valid_d;
  logic [CNT_W-1:0] r_num_orig, r_num_dup;
  logic             w_fifo_full, w_go_dup, w_push, w_pop;

  // A zero register field stays zero; otherwise its bit 4 moves it to r16-r31.
  function automatic logic [31:0] dup_xform(input logic [31:0] x);
    logic [5:0]  op;
    logic [31:0] y;
    op = x[31:26];
    y  = x;
    if (op == 6'b111000) begin
      if (|x[25:21]) y[25] = 1'b1;
      if (|x[20:16]) y[20] = 1'b1;
      if (|x[15:11]) y[15] = 1'b1;
    end else if (op == 6'b100111 || (op >= 6'b101001 && op <= 6'b101100) ||
                 op == 6'b101110) begin
      if (|x[25:21]) y[25] = 1'b1;
      if (|x[20:16]) y[20] = 1'b1;
    end else if (op >= 6'b100001 && op <= 6'b100110) begin
      if (|x[25:21]) y[25] = 1'b1;
      y[14] = 1'b1;
    end else if (op >= 6'b110101 && op <= 6'b110111) begin
      if (|x[15:11]) y[15] = 1'b1;
      y[24] = 1'b1;
    end
    return y;
  endfunction

  assign w_fifo_full = (r_fifo_cnt == FULL_CNT);
  assign w_go_dup    = !stall && (r_state == S_ORIG) && (r_fifo_cnt != '0) &&
                       (exec_dup || w_fifo_full);
  assign ifu_ready   = (r_state == S_ORIG) && !stall && !w_fifo_full && !w_go_dup;
  assign w_push      = ifu_valid && ifu_ready;
  assign w_pop       = (r_state == S_DUP) && !stall;

  always_comb begin
    w_state_d = r_state;
    w_out_d   = NOP;
    w_valid_d = 1'b0;
    case (r_state)
      S_ORIG: begin
        if (w_push) begin
          w_out_d   = ifu_inst;
          w_valid_d = 1'b1;
        end
        if (w_go_dup) w_state_d = S_DUP;
      end
      S_DUP: begin
        w_out_d   = dup_xform(r_fifo[r_rd_ptr]);
        w_valid_d = 1'b1;
        if (r_fifo_cnt == CNT_W'(1)) w_state_d = S_DONE;
      end
      S_DONE:  w_state_d = S_DONE;
      default: w_state_d = S_ORIG;
    endcase
  end

  // Queue storage carries no reset; occupancy is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= ifu_inst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_ORIG;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_cnt   <= '0;
      r_inst_out   <= NOP;
      r_inst_valid <= 1'b0;
      r_num_orig   <= '0;
      r_num_dup    <= '0;
    end else if (!stall) begin
      r_state      <= w_state_d;
      r_inst_out   <= w_out_d;
      r_inst_valid <= w_valid_d;
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        r_num_orig <= r_num_orig + CNT_W'(1);
      end else if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        r_num_dup  <= r_num_dup + CNT_W'(1);
      end
    end
  end

  assign inst_out    = r_inst_out;
  assign inst_valid  = r_inst_valid;
  assign dup_mode    = (r_state != S_ORIG);
  assign num_orig    = r_num_orig;
  assign num_dup     = r_num_dup;
  assign qed_ready   = (r_state == S_DONE) && (r_num_orig == r_num_dup) &&
                       (r_num_orig != '0);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_qed_issue_sequencer.sv
// Bench for qed_issue_sequencer: directed and random steps compared each cycle
// against a queue-based model of the original/duplicate issue sequence.
module tb_qed_issue_sequencer;

  localparam int          DEPTH = 16;
  localparam int          CNT_W = 5;
  localparam logic [31:0] NOP   = 32'h1500_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b0, exec_dup = 1'b0, ifu_valid = 1'b0, stall = 1'b0;
  logic [31:0]      ifu_inst = '0;
  logic             ifu_ready, inst_valid, dup_mode, qed_ready;
  logic [31:0]      inst_out;
  logic [CNT_W-1:0] num_orig, num_dup;
  logic [1:0]       o_dbg_state;

  qed_issue_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .exec_dup(exec_dup), .ifu_inst(ifu_inst),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .stall(stall),
    .inst_out(inst_out), .inst_valid(inst_valid), .dup_mode(dup_mode),
    .num_orig(num_orig), .num_dup(num_dup), .qed_ready(qed_ready),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard: originals awaiting replay, plus the abstract run state
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          m_phase = 0;  // 0 issuing originals, 1 replaying, 2 finished
  int          m_norig = 0, m_ndup = 0;
  logic [31:0] m_out = NOP;
  logic        m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tag_field(input logic [31:0] y, input int lo);
    if (((y >> lo) & 32'd31) != 0) return y | (32'h10 << lo);
    return y;
  endfunction

  function automatic logic [31:0] dup_model(input logic [31:0] x);
    int          op;
    logic [31:0] y;
    bit          r_t, i_t, ld_t, st_t;
    op   = int'(x >> 26);
    y    = x;
    r_t  = (op == 56);
    i_t  = (op == 39) || (op >= 41 && op <= 44) || (op == 46);
    ld_t = (op >= 33 && op <= 38);
    st_t = (op >= 53 && op <= 55);
    if (r_t || i_t || ld_t) y = tag_field(y, 21);
    if (r_t || i_t)         y = tag_field(y, 16);
    if (r_t || st_t)        y = tag_field(y, 11);
    if (ld_t) y = y | 32'h0000_4000;
    if (st_t) y = y | 32'h0100_0000;
    return y;
  endfunction

  function automatic logic [31:0] rand_inst();
    int          ops[19] = '{56, 39, 41, 42, 43, 44, 46, 33, 34, 35, 36, 37, 38,
                             53, 54, 55, 5, 17, 0};
    logic [31:0] x;
    x = $urandom();
    x[31:26] = 6'(ops[$urandom_range(0, 18)]);
    if ($urandom_range(0, 2) == 0) x[25:21] = '0;
    if ($urandom_range(0, 2) == 0) x[20:16] = '0;
    if ($urandom_range(0, 2) == 0) x[15:11] = '0;
    return x;
  endfunction

  task automatic check_outputs();
    chk("inst_out", inst_out, m_out);
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("num_orig", 32'(num_orig), 32'(m_norig));
    chk("num_dup", 32'(num_dup), 32'(m_ndup));
    chk("dup_mode", 32'(dup_mode), 32'(m_phase != 0));
    chk("qed_ready", 32'(qed_ready),
        32'(m_phase == 2 && m_norig == m_ndup && m_norig != 0));
  endtask

  // driver: one clock cycle of stimulus, model update, and output check
  task automatic tick(input logic r, input logic v, input logic [31:0] inst,
                      input logic ed, input logic st);
    bit go, rdy;
    int sz;
    rst = r; ifu_valid = v; ifu_inst = inst; exec_dup = ed; stall = st;
    #1;
    sz  = exp_q.size();
    go  = !st && m_phase == 0 && sz > 0 && (ed || sz == DEPTH);
    rdy = m_phase == 0 && !st && sz < DEPTH && !go;
    if (!r) chk("ifu_ready", 32'(ifu_ready), 32'(rdy));
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      m_phase = 0; m_norig = 0; m_ndup = 0; m_out = NOP; m_valid = 1'b0;
    end else if (!st) begin
      m_out = NOP; m_valid = 1'b0;
      if (m_phase == 0) begin
        if (v && rdy) begin
          exp_q.push_back(inst);
          m_out = inst; m_valid = 1'b1; m_norig++;
        end
        if (go) m_phase = 1;
      end else if (m_phase == 1) begin
        m_out = dup_model(exp_q.pop_front());
        m_valid = 1'b1; m_ndup++;
        if (exp_q.size() == 0) m_phase = 2;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input logic ed);
    tick(1'b1, 1'b0, '0, ed, 1'b0);
  endtask

  task automatic finish_run(input int bound);
    int n = 0;
    while (m_phase != 2 && n < bound) begin
      tick(1'b0, 1'b1, rand_inst(), 1'b1, 1'($urandom_range(0, 3) == 0));
      n++;
    end
    checks++;
    assert (m_phase == 2) else begin
      errors++;
      $error("FAIL run_timeout observed=%0d expected=%0d", n, bound);
    end
  endtask

  task automatic single(input string tag, input logic [31:0] inst, input logic [31:0] exp_dup);
    do_reset(1'b0);
    tick(1'b0, 1'b1, inst, 1'b0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk(tag, inst_out, exp_dup);
    chk({tag, "_qed_ready"}, 32'(qed_ready), 32'd1);
  endtask

  initial begin
    // reset state, exec_dup ignored while empty
    do_reset(1'b1);
    chk("reset_inst_out", inst_out, NOP);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("empty_exec_dup_mode", 32'(dup_mode), 32'd0);

    // single-instruction transforms
    single("dup_add", 32'hE061_1000, 32'hE271_9000);
    chk("add_num_orig", 32'(num_orig), 32'd1);
    single("dup_addi", 32'h9C00_0005, 32'h9C00_0005);
    single("dup_lwz", 32'h8440_0000, 32'h8640_4000);
    single("dup_sw", 32'hD400_2800, 32'hD500_A800);

    // fill the queue without exec_dup: full forces the switch
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b1, rand_inst(), 1'b0, 1'b0);
    tick(1'b0, 1'b1, rand_inst(), 1'b0, 1'b0);
    chk("full_forced_dup", 32'(dup_mode), 32'd1);
    for (int i = 0; i < DEPTH; i++)
      tick(1'b0, 1'($urandom_range(0, 1)), rand_inst(), 1'b0, 1'b0);
    chk("full_qed_ready", 32'(qed_ready), 32'd1);
    chk("full_num_dup", 32'(num_dup), 32'(DEPTH));

    // stall held three cycles in the middle of replay
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, rand_inst(), 1'b0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, rand_inst(), 1'b1, 1'b1);
    finish_run(10);

    // reset while four entries are queued for replay
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, rand_inst(), 1'b0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    do_reset(1'b0);
    chk("midrun_reset_mode", 32'(dup_mode), 32'd0);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, rand_inst(), 1'b0, 1'b0);
    finish_run(10);
    chk("after_reset_num_dup", 32'(num_dup), 32'd2);

    // randomized runs
    for (int run = 0; run < 8; run++) begin
      do_reset(1'($urandom_range(0, 1)));
      for (int n = 0; n < 60 && m_phase == 0; n++)
        tick(1'b0, 1'($urandom_range(0, 3) != 0), rand_inst(),
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0));
      finish_run(80);
      for (int n = 0; n < 3; n++)
        tick(1'b0, 1'b1, rand_inst(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
